// File: rtl/boot_pkg.sv
// Shared types and frame constants for the serial program loader.
package boot_pkg;

  localparam int BYTE_W  = 8;
  localparam int CNT_W   = 16;
  localparam int INSTR_W = 32;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_WORD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // States in which a frame is in flight: timeout and framing errors abort here.
  function automatic logic in_frame(input boot_state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_WORD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, half-bit start confirm, mid-bit sampling.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TICK_W       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TICK_W-1:0] FULL_LOAD = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_LOAD = TICK_W'(CLKS_PER_BIT / 2 - 1);

  logic              rx_meta, rx_sync;
  rx_state_t         state, state_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic [BYTE_W-1:0] shift, shift_nxt;
  logic              valid_nxt, ferr_nxt;

  assign rx_data = shift;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Bit-timing down-counter and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick      <= tick_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // Next-state: each phase waits for the tick counter to reach zero, then acts.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_nxt = RX_START;
          tick_nxt  = HALF_LOAD;
        end
      end
      RX_START: begin
        if (tick == '0) begin
          if (!rx_sync) begin
            state_nxt = RX_DATA;
            tick_nxt  = FULL_LOAD;
            bit_nxt   = '0;
          end else begin
            state_nxt = RX_IDLE;
          end
        end else begin
          tick_nxt = tick - TICK_W'(1);
        end
      end
      RX_DATA: begin
        if (tick == '0) begin
          shift_nxt = {rx_sync, shift[BYTE_W-1:1]};
          tick_nxt  = FULL_LOAD;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          tick_nxt = tick - TICK_W'(1);
        end
      end
      RX_STOP: begin
        if (tick == '0) begin
          // Returning to idle at mid stop bit leaves half a bit to catch the next start edge.
          state_nxt = RX_IDLE;
          if (rx_sync) valid_nxt = 1'b1;
          else         ferr_nxt  = 1'b1;
        end else begin
          tick_nxt = tick - TICK_W'(1);
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/boot_loader.sv
// Framed serial program loader feeding the instruction memory write port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for SYNC after reset
// ST_CNT_LO | expecting word count low byte
// ST_CNT_HI | expecting word count high byte, range-checks the count
// ST_WORD   | assembling LE instruction bytes, one write per 4 bytes
// ST_CHECK  | expecting checksum byte
// ST_DONE   | image loaded and verified, CPU released
// ST_ERROR  | frame aborted, CPU held, waiting for a new SYNC
module boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int DEPTH          = 1024,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ADDR_W         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_instr,
  output logic               cpu_hold,
  output logic               boot_done,
  output logic               boot_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid, rx_ferr;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (rx_ferr)
  );

  boot_state_t        state, state_nxt;
  logic [CNT_W-1:0]   word_cnt, word_cnt_nxt;
  logic [CNT_W-1:0]   ptr, ptr_nxt;
  logic [1:0]         byte_idx, byte_idx_nxt;
  logic [INSTR_W-1:0] asm_reg, asm_nxt;
  logic [BYTE_W-1:0]  cks, cks_nxt;
  logic [TMO_W-1:0]   tmo, tmo_nxt;
  logic               wr_en_nxt, hold_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0]  wr_addr_nxt;
  logic [INSTR_W-1:0] wr_instr_nxt;
  logic [CNT_W-1:0]   n_full;

  assign n_full = {rx_data, word_cnt[BYTE_W-1:0]};

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      ptr       <= '0;
      byte_idx  <= '0;
      asm_reg   <= '0;
      cks       <= '0;
      tmo       <= TMO_LOAD;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_instr  <= '0;
      cpu_hold  <= 1'b0;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      word_cnt  <= word_cnt_nxt;
      ptr       <= ptr_nxt;
      byte_idx  <= byte_idx_nxt;
      asm_reg   <= asm_nxt;
      cks       <= cks_nxt;
      tmo       <= tmo_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_instr  <= wr_instr_nxt;
      cpu_hold  <= hold_nxt;
      boot_done <= done_nxt;
      boot_err  <= err_nxt;
    end
  end

  // Frame decode, checksum, word assembly and inter-byte timeout.
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    ptr_nxt      = ptr;
    byte_idx_nxt = byte_idx;
    asm_nxt      = asm_reg;
    cks_nxt      = cks;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_instr_nxt = wr_instr;
    hold_nxt     = cpu_hold;
    done_nxt     = boot_done;
    err_nxt      = boot_err;

    // Timeout reloads on every byte and whenever no frame is in flight.
    if (rx_valid || !in_frame(state)) tmo_nxt = TMO_LOAD;
    else                              tmo_nxt = tmo - TMO_W'(1);

    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_nxt    = ST_CNT_LO;
          hold_nxt     = 1'b1;
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
          ptr_nxt      = '0;
          cks_nxt      = '0;
          byte_idx_nxt = '0;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          word_cnt_nxt = {{(CNT_W-BYTE_W){1'b0}}, rx_data};
          cks_nxt      = cks ^ rx_data;
          state_nxt    = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid) begin
          word_cnt_nxt = n_full;
          cks_nxt      = cks ^ rx_data;
          if ({16'h0000, n_full} > 32'(DEPTH)) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else if (n_full == '0) begin
            state_nxt = ST_CHECK;
          end else begin
            state_nxt = ST_WORD;
          end
        end
      end
      ST_WORD: begin
        if (rx_valid) begin
          asm_nxt      = {rx_data, asm_reg[INSTR_W-1:BYTE_W]};
          cks_nxt      = cks ^ rx_data;
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            wr_en_nxt    = 1'b1;
            wr_addr_nxt  = ptr[ADDR_W-1:0];
            wr_instr_nxt = asm_nxt;
            ptr_nxt      = ptr + 16'd1;
            if (ptr + 16'd1 == word_cnt) state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_data == cks) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            hold_nxt  = 1'b0;
          end else begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Aborts inside a frame; cpu_hold is already high and simply stays there.
    if (in_frame(state) && (rx_ferr || (!rx_valid && tmo == '0))) begin
      state_nxt = ST_ERROR;
      err_nxt   = 1'b1;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frames driven bit-serially, writes logged at negedge.
module tb_boot_loader;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 1024;
  localparam int TMO      = 2000;
  localparam int ADDR_W   = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx  = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_instr;
  logic              cpu_hold, boot_done, boot_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_instr[$];
  int          wr_long = 0;
  logic        wr_en_d = 1'b0;

  boot_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_instr  (wr_instr),
    .cpu_hold  (cpu_hold),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(32'(wr_addr));
      wq_instr.push_back(wr_instr);
      if (wr_en_d) wr_long++;
    end
    wr_en_d = wr_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done, input logic err);
    check({tag, ".hold"}, 32'(cpu_hold), 32'(hold));
    check({tag, ".done"}, 32'(boot_done), 32'(done));
    check({tag, ".err"}, 32'(boot_err), 32'(err));
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk);
    rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(CPB);
    end
    rx = stop_bit;
    wait_clk(CPB);
    rx = 1'b1;
    if (!stop_bit) wait_clk(2 * CPB);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
    wait_clk(2);
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_instr.delete();
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] addr, input logic [31:0] instr);
    if (wq_addr.size() > idx) begin
      check({tag, ".addr"}, wq_addr[idx], addr);
      check({tag, ".instr"}, wq_instr[idx], instr);
    end else begin
      check({tag, ".present"}, 32'(wq_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    wait_clk(3);
    // reset values
    check("rst.wr_en", 32'(wr_en), 32'd0);
    check("rst.wr_addr", 32'(wr_addr), 32'd0);
    check("rst.wr_instr", wr_instr, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    wait_clk(5);

    // garbage and a framing error in IDLE are ignored
    clear_log();
    send_bytes('{8'h00, 8'h7F, 8'hFF});
    send_byte(8'h55, 1'b0);
    wait_clk(2);
    check_status("garbage", 1'b0, 1'b0, 1'b0);
    // empty image: N=0, CKS=0
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00});
    check_status("empty", 1'b0, 1'b1, 1'b0);
    check("empty.nwr", 32'(wq_addr.size()), 32'd0);

    // two-word image, good checksum 0x93
    clear_log();
    send_byte(8'hA5);
    wait_clk(2);
    check_status("sync", 1'b1, 1'b0, 1'b0);
    send_bytes('{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
                 8'h13, 8'h01, 8'h10, 8'h00, 8'h93});
    check("good.nwr", 32'(wq_addr.size()), 32'd2);
    check_write("good.w0", 0, 32'd0, 32'h0000_0093);
    check_write("good.w1", 1, 32'd1, 32'h0010_0113);
    check_status("good", 1'b0, 1'b1, 1'b0);
    check("good.hold_addr", 32'(wr_addr), 32'd1);

    // reset mid-frame after the second word byte
    clear_log();
    send_bytes('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.wr_en", 32'(wr_en), 32'd0);
    check("midrst.wr_addr", 32'(wr_addr), 32'd0);
    check("midrst.wr_instr", wr_instr, 32'd0);
    check_status("midrst", 1'b0, 1'b0, 1'b0);
    send_bytes('{8'h33, 8'h44, 8'h45});
    check_status("midrst.tail", 1'b0, 1'b0, 1'b0);
    check("midrst.nwr", 32'(wq_addr.size()), 32'd0);

    // bad checksum: writes still land, then error
    clear_log();
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
                 8'h13, 8'h01, 8'h10, 8'h00, 8'h94});
    check("badcks.nwr", 32'(wq_addr.size()), 32'd2);
    check_write("badcks.w1", 1, 32'd1, 32'h0010_0113);
    check_status("badcks", 1'b1, 1'b0, 1'b1);

    // N = DEPTH+1 rejected at CNT_HI
    clear_log();
    send_bytes('{8'hA5, 8'h01, 8'h04});
    check_status("ovf", 1'b1, 1'b0, 1'b1);
    check("ovf.nwr", 32'(wq_addr.size()), 32'd0);
    // recovery: one word 0x12345678, CKS = 01^00^78^56^34^12 = 09
    send_bytes('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09});
    check("recov.nwr", 32'(wq_addr.size()), 32'd1);
    check_write("recov.w0", 0, 32'd0, 32'h1234_5678);
    check_status("recov", 1'b0, 1'b1, 1'b0);

    // N = DEPTH accepted; a framing error then aborts the frame
    clear_log();
    send_bytes('{8'hA5, 8'h00, 8'h04});
    check_status("depth", 1'b1, 1'b0, 1'b0);
    send_byte(8'h13, 1'b0);
    wait_clk(2);
    check_status("ferr", 1'b1, 1'b0, 1'b1);
    check("ferr.nwr", 32'(wq_addr.size()), 32'd0);

    // inter-byte timeout with a partial word
    clear_log();
    send_bytes('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h01});
    wait_clk(1900);
    check_status("tmo.early", 1'b1, 1'b0, 1'b0);
    wait_clk(200);
    check_status("tmo", 1'b1, 1'b0, 1'b1);
    check("tmo.nwr", 32'(wq_addr.size()), 32'd0);

    check("wr_en.one_cycle", 32'(wr_long), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial program loader sitting directly upstream of the instruction memory write port. It receives a framed program image over a UART RX line and assembles little-endian bytes into 32-bit instructions. Each instruction is driven into instruction memory as a single-cycle write with an incrementing word address. The CPU is held in reset for the duration of a load, and completion or failure is flagged.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz
- `BAUD`, 115_200, UART bit rate (8N1)
- `DEPTH`, 1024, instruction memory depth in words; `ADDR_W = $clog2(DEPTH)`
- `TIMEOUT_CYCLES`, 1_000_000, max idle cycles between bytes inside a frame
- `clk`  in  1  single system clock
- `rst`  in  1  reset, synchronous, active-high
- `rx`  in  1  asynchronous UART serial input, idle high
- `wr_en`  out  1  one-cycle write strike to instruction memory
- `wr_addr`  out  ADDR_W  word address of current write
- `wr_instr`  out  32  assembled instruction
- `cpu_hold`  out  1  holds CPU/PC in reset while high
- `boot_done`  out  1  last frame loaded and checksum good
- `boot_err`  out  1  last frame aborted

## Operation
- Frame format: `SYNC`=0xA5, `CNT_LO`, `CNT_HI` (word count N, 16-bit LE), N×4 instruction bytes (LE: first byte = bits [7:0]), `CKS`.
- `CKS` = XOR of every byte after `SYNC`, including count bytes, excluding `CKS`.
- States: IDLE, CNT_LO, CNT_HI, WORD, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR: non-0xA5 bytes are ignored. 0xA5 → CNT_LO, with `cpu_hold`=1, `boot_done`=0, `boot_err`=0, word pointer=0, checksum=0, byte index=0.
- CNT_LO → CNT_HI on the next byte.
- CNT_HI on a byte:
  - N > DEPTH → ERROR.
  - N = 0 → CHECK.
  - Otherwise → WORD.
- WORD: shift bytes into a 32-bit assembly register. On the 4th byte, pulse `wr_en` and increment the pointer. After word N → CHECK.
- CHECK on a byte:
  - Matches the running XOR → DONE (`boot_done`=1, `cpu_hold`=0).
  - Otherwise → ERROR.
- ERROR: `boot_err`=1 sticky, `cpu_hold` stays 1. Only a new 0xA5 leaves ERROR.
- Inter-byte timeout: in CNT_LO/CNT_HI/WORD/CHECK, TIMEOUT_CYCLES with no byte → ERROR. The counter clears on every received byte.
- UART framing error (stop bit = 0): byte discarded. In CNT_LO..CHECK → ERROR; in IDLE/DONE/ERROR → ignored.
- Words written before an abort remain in memory. No rollback.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_instr`=0, `cpu_hold`=0, `boot_done`=0, `boot_err`=0; state IDLE; counters 0.
- `rst` asserted mid-frame aborts immediately. Next cycle all outputs are at reset values.
- `wr_en` is high exactly 1 cycle, in the cycle after the `rx_valid` of the 4th word byte. `wr_addr`/`wr_instr` are valid in the same cycle and held until the next write.
- `wr_addr` = k for the k-th word (0-based). It never exceeds N-1 ≤ DEPTH-1; no wrap.
- Status outputs update in the cycle after the `rx_valid` of the deciding byte. A timeout updates them in the cycle after the counter hits TIMEOUT_CYCLES.
- `cpu_hold` rises the cycle after `SYNC` is accepted.
- UART RX:
  - 2-FF synchronizer on `rx`.
  - Start bit confirmed at half-bit; data sampled mid-bit; `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division).
  - `rx_valid` is a 1-cycle pulse at mid stop bit.
  - Back-to-back bytes are supported at full baud.

## Structure
- Package `boot_pkg`: state enum, `SYNC_BYTE`=8'hA5, frame field widths.
- Sub-module `uart_rx`:
  - Parameters `CLK_FREQ`, `BAUD`.
  - Outputs `rx_data[7:0]`, `rx_valid`, `frame_err`.
  - Own bit-timing counter and synchronizer.
- `boot_loader` holds the frame FSM, checksum, timeout counter and word assembly.

## Test plan
- Frame A5 02 00 93 00 00 00 13 01 10 00 93 → `wr_en` at addr 0 data 0x00000093, then addr 1 data 0x00100113; `boot_done`=1, `cpu_hold`=0.
- Same frame with CKS 0x94 → two writes occur; `boot_err`=1, `cpu_hold`=1, `boot_done`=0.
- A5 01 04 (N=1025, DEPTH=1024) → ERROR after CNT_HI, no `wr_en`. A following good frame recovers to `boot_done`.
- Bytes 0x00 0x7F 0xFF in IDLE, then A5 00 00 00 → garbage ignored; no writes; `boot_done`=1.
- A5 01 00 13 01 then silence > TIMEOUT_CYCLES (bench uses 2000) → `boot_err`=1, no `wr_en`.
- `rst` pulsed after the 2nd word byte of a 1-word frame → all outputs 0 next cycle. Remaining bytes are ignored until a new A5.
